// File: rtl/r88_mem_responder_if.sv
// rtl/r88_mem_responder_if.sv - Rocket88 external bus bundle: address, request levels, completion and decode
//
// Signals:
//   extA      16-bit address from the core
//   readMem   read request level
//   writeMem  write request level
//   memReady  one-cycle completion pulse from the responder
//   busErr    one-cycle pulse on a simultaneous read/write request to the window
//   selected  combinational window decode of extA
//   wpFault   (R88_WRITE_PROTECT_EN only) write to a protected location
// The shared tristate data bus extD is not carried here; it stays a plain
// inout on each responder so several responders can resolve onto one net.
interface r88_mem_responder_if;
    logic [15:0] extA;
    logic        readMem;
    logic        writeMem;
    logic        memReady;
    logic        busErr;
    logic        selected;
`ifdef R88_WRITE_PROTECT_EN
    logic        wpFault;
`endif

    modport master (
        output extA, readMem, writeMem,
        input  memReady, busErr, selected
`ifdef R88_WRITE_PROTECT_EN
        , input wpFault
`endif
    );

    modport slave (
        input  extA, readMem, writeMem,
        output memReady, busErr, selected
`ifdef R88_WRITE_PROTECT_EN
        , output wpFault
`endif
    );
endinterface

// File: rtl/r88_mem_responder.sv
// rtl/r88_mem_responder.sv - Rocket88 external-bus RAM responder with programmable wait states
//
// Purpose: answers readMem/writeMem requests that fall inside the window
// BASE_ADDR[15:ADDR_BITS] from an internal 2^ADDR_BITS-byte RAM, inserting
// WAIT_STATES wait cycles and pulsing memReady for one cycle on completion.
// extD is driven only while a selected read holds data; otherwise high-Z.
//
// Optional feature macro: R88_WRITE_PROTECT_EN
//   adds parameter WP_BASE and bus output wpFault; writes at or above WP_BASE
//   complete the handshake but leave RAM untouched.
//
// Ports:
//   sysClock    system clock, rising edge
//   resetReq_n  asynchronous active-low reset
//   bus         r88_mem_responder_if.slave (extA, readMem, writeMem,
//               memReady, busErr, selected[, wpFault])
//   extD        8-bit shared tristate data bus
module r88_mem_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 1
`ifdef R88_WRITE_PROTECT_EN
    ,
    parameter int          WP_BASE     = (2 ** ADDR_BITS) / 2
`endif
) (
    input  logic               sysClock,
    input  logic               resetReq_n,
    r88_mem_responder_if.slave bus,
    inout  wire  [7:0]         extD
);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND, HOLD} stateT;

    stateT                 state;
    stateT                 nextState;
    logic [3:0]            waitCnt;
    logic [ADDR_BITS-1:0]  addrQ;
    logic                  isWrite;
    logic [7:0]            dOut;
    logic                  driveEn;
    logic                  busErrQ;

    logic                  reqActive;
    logic                  accept;
    logic                  conflict;
    logic [ADDR_BITS-1:0]  entryAddr;
    logic                  entryIsWrite;
    logic                  wpHit;
    logic                  ramWe;

    logic [7:0]            mem [2**ADDR_BITS];

    assign bus.selected = (bus.extA[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);

    // Request level for the direction captured at acceptance.
    assign reqActive = isWrite ? bus.writeMem : bus.readMem;
    assign accept    = (state == IDLE) && bus.selected && (bus.readMem ^ bus.writeMem);
    assign conflict  = (state == IDLE) && bus.selected && bus.readMem && bus.writeMem;

    // With zero wait states RESPOND is entered straight from IDLE, before
    // addrQ/isWrite hold the new request, so take them from the bus then.
    assign entryAddr    = (state == IDLE) ? bus.extA[ADDR_BITS-1:0] : addrQ;
    assign entryIsWrite = (state == IDLE) ? bus.writeMem : isWrite;

`ifdef R88_WRITE_PROTECT_EN
    localparam logic [ADDR_BITS:0] WP_LIMIT = (ADDR_BITS+1)'(WP_BASE);
    assign wpHit = ({1'b0, addrQ} >= WP_LIMIT);
`else
    assign wpHit = 1'b0;
`endif

    // State register
    always_ff @(posedge sysClock or negedge resetReq_n) begin
        if (!resetReq_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nextState = (WAIT_STATES > 0) ? WAIT : RESPOND;
                end
            end
            WAIT: begin
                if (!reqActive) begin
                    nextState = IDLE;
                end else if (waitCnt == 4'd1) begin
                    nextState = RESPOND;
                end
            end
            RESPOND: begin
                nextState = HOLD;
            end
            HOLD: begin
                if (!reqActive) begin
                    nextState = IDLE;
                end
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.memReady = 1'b0;
        ramWe        = 1'b0;
        if (state == RESPOND) begin
            bus.memReady = 1'b1;
            ramWe        = isWrite && !wpHit;
        end
    end

`ifdef R88_WRITE_PROTECT_EN
    assign bus.wpFault = (state == RESPOND) && isWrite && wpHit;
`endif

    assign bus.busErr = busErrQ;

    // Request capture, wait counter and read data register
    always_ff @(posedge sysClock or negedge resetReq_n) begin
        if (!resetReq_n) begin
            waitCnt <= 4'd0;
            addrQ   <= '0;
            isWrite <= 1'b0;
            dOut    <= 8'h00;
            driveEn <= 1'b0;
            busErrQ <= 1'b0;
        end else begin
            busErrQ <= conflict;

            if (accept) begin
                addrQ   <= bus.extA[ADDR_BITS-1:0];
                isWrite <= bus.writeMem;
                waitCnt <= 4'(WAIT_STATES);
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - 4'd1;
            end

            // Data is registered on the edge entering RESPOND so it is
            // already on extD in the memReady cycle.
            if (nextState == RESPOND && !entryIsWrite) begin
                dOut    <= mem[entryAddr];
                driveEn <= 1'b1;
            end else if (state == HOLD && nextState == IDLE) begin
                driveEn <= 1'b0;
            end
        end
    end

    // RAM is not reset; the write lands only on the edge leaving RESPOND.
    always_ff @(posedge sysClock) begin
        if (ramWe) begin
            mem[addrQ] <= extD;
        end
    end

    assign extD = driveEn ? dOut : 8'hzz;

endmodule

// File: tb/tb_r88_mem_responder.sv
// tb/tb_r88_mem_responder.sv - self-checking bench: three responders (0/1/3 wait states) on shared stimulus
module tb_r88_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic [15:0] tbA;
    logic        tbRd;
    logic        tbWr;
    logic        tbDrv;
    logic [7:0]  tbData;

    r88_mem_responder_if bus0 ();
    r88_mem_responder_if bus1 ();
    r88_mem_responder_if bus3 ();

    // Pulled-up data nets: a released bus reads 8'hFF.
    tri1 [7:0] d0;
    tri1 [7:0] d1;
    tri1 [7:0] d3;

    assign bus0.extA = tbA;  assign bus0.readMem = tbRd;  assign bus0.writeMem = tbWr;
    assign bus1.extA = tbA;  assign bus1.readMem = tbRd;  assign bus1.writeMem = tbWr;
    assign bus3.extA = tbA;  assign bus3.readMem = tbRd;  assign bus3.writeMem = tbWr;

    assign d0 = tbDrv ? tbData : 8'hzz;
    assign d1 = tbDrv ? tbData : 8'hzz;
    assign d3 = tbDrv ? tbData : 8'hzz;

    r88_mem_responder #(.WAIT_STATES(0)) u0 (.sysClock(clk), .resetReq_n(rstN), .bus(bus0), .extD(d0));
    r88_mem_responder #(.WAIT_STATES(1)) u1 (.sysClock(clk), .resetReq_n(rstN), .bus(bus1), .extD(d1));
    r88_mem_responder #(.WAIT_STATES(3)) u3 (.sysClock(clk), .resetReq_n(rstN), .bus(bus3), .extD(d3));

    logic [2:0] rdy;
    logic [2:0] err;
    logic [2:0] sel;
    logic [7:0] dv [3];
    assign rdy = {bus3.memReady, bus1.memReady, bus0.memReady};
    assign err = {bus3.busErr, bus1.busErr, bus0.busErr};
    assign sel = {bus3.selected, bus1.selected, bus0.selected};
    assign dv[0] = d0;
    assign dv[1] = d1;
    assign dv[2] = d3;
`ifdef R88_WRITE_PROTECT_EN
    logic [2:0] wpf;
    assign wpf = {bus3.wpFault, bus1.wpFault, bus0.wpFault};
`endif

    int nCmp = 0;
    int nBad = 0;

    // Reference model: per-responder RAM image and which bytes are defined.
    logic [7:0] model [3][256];
    bit         known [3][256];

    function automatic int wsOf(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // Request held high for edges 0..L-1. A responder completes only if the
    // request survives every wait cycle (L > waitStates); memReady then
    // appears after edge waitStates, and read data stays on the bus until the
    // request is seen low in HOLD.
    task automatic runTxn(input logic [15:0] a, input bit wr, input bit rd,
                          input logic [7:0] wdata, input int L, input string tag);
        bit         inWin;
        bit         both;
        bit         prot;
        bit         done [3];
        int         rel [3];
        logic [7:0] expd [3];
        bit         kn [3];
        logic [7:0] lo;
        int         nCyc;
        logic       eRdy;
        logic       eErr;
        logic [7:0] eD;
        lo    = a[7:0];
        inWin = (a[15:8] == 8'h00);
        both  = wr && rd;
        prot  = 1'b0;
`ifdef R88_WRITE_PROTECT_EN
        prot  = (lo >= 8'h80);
`endif
        for (int k = 0; k < 3; k++) begin
            done[k] = inWin && !both && (wr || rd) && (L > wsOf(k));
            rel[k]  = (L > wsOf(k) + 2) ? L : wsOf(k) + 2;
            expd[k] = model[k][lo];
            kn[k]   = known[k][lo];
        end
        nCyc = ((L > 5) ? L : 5) + 2;

        tbA = a; tbRd = rd; tbWr = wr; tbData = wdata; tbDrv = wr;
        for (int i = 0; i < nCyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                eRdy = done[k] && (i == wsOf(k));
                nCmp++;
                if (rdy[k] !== eRdy) begin
                    nBad++;
                    $display("FAIL %s memReady dut%0d cyc%0d got %b want %b", tag, k, i, rdy[k], eRdy);
                end
                eErr = inWin && both && (i == 0);
                nCmp++;
                if (err[k] !== eErr) begin
                    nBad++;
                    $display("FAIL %s busErr dut%0d cyc%0d got %b want %b", tag, k, i, err[k], eErr);
                end
`ifdef R88_WRITE_PROTECT_EN
                nCmp++;
                if (wpf[k] !== (eRdy && wr && prot)) begin
                    nBad++;
                    $display("FAIL %s wpFault dut%0d cyc%0d got %b want %b", tag, k, i, wpf[k], eRdy && wr && prot);
                end
`endif
                if (rd && !wr) begin
                    if (done[k] && i >= wsOf(k) && i < rel[k]) begin
                        if (kn[k]) begin
                            nCmp++;
                            if (dv[k] !== expd[k]) begin
                                nBad++;
                                $display("FAIL %s readData dut%0d cyc%0d got %h want %h", tag, k, i, dv[k], expd[k]);
                            end
                        end
                    end else begin
                        nCmp++;
                        if (dv[k] !== 8'hFF) begin
                            nBad++;
                            $display("FAIL %s busReleased dut%0d cyc%0d got %h want %h", tag, k, i, dv[k], 8'hFF);
                        end
                    end
                end
            end
            if (i + 1 >= L) begin
                tbRd = 1'b0;
                tbWr = 1'b0;
            end
            if (i + 1 >= L + 1) tbDrv = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            if (done[k] && wr && !prot) begin
                model[k][lo] = wdata;
                known[k][lo] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        tbA = 16'h0000; tbRd = 1'b0; tbWr = 1'b0; tbDrv = 1'b0; tbData = 8'h00;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nCmp++;
        if (rdy !== 3'b000) begin nBad++; $display("FAIL reset memReady got %b want %b", rdy, 3'b000); end
        nCmp++;
        if (err !== 3'b000) begin nBad++; $display("FAIL reset busErr got %b want %b", err, 3'b000); end
        for (int k = 0; k < 3; k++) begin
            nCmp++;
            if (dv[k] !== 8'hFF) begin nBad++; $display("FAIL reset extD dut%0d got %h want %h", k, dv[k], 8'hFF); end
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_select();
        logic [15:0] addrs [4];
        logic [2:0]  want;
        addrs[0] = 16'h0012; addrs[1] = 16'h0112; addrs[2] = 16'h00FF; addrs[3] = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            tbA = addrs[i];
            #1;
            want = (addrs[i][15:8] == 8'h00) ? 3'b111 : 3'b000;
            nCmp++;
            if (sel !== want) begin nBad++; $display("FAIL selected extA=%h got %b want %b", addrs[i], sel, want); end
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        runTxn(16'h0034, 1'b1, 1'b0, 8'hA5, 2, "wr34");
        runTxn(16'h0034, 1'b0, 1'b1, 8'h00, 4, "rd34");
    endtask

    task automatic test_zero_wait();
        runTxn(16'h00FF, 1'b1, 1'b0, 8'h3C, 2, "wrFF");
        runTxn(16'h00FF, 1'b0, 1'b1, 8'h00, 4, "rdFFhold");
    endtask

    task automatic test_deselect();
        runTxn(16'h0134, 1'b1, 1'b0, 8'hFF, 3, "wrDesel");
        runTxn(16'h0134, 1'b0, 1'b1, 8'h00, 3, "rdDesel");
        runTxn(16'h0034, 1'b0, 1'b1, 8'h00, 3, "rd34after");
    endtask

    task automatic test_conflict_abort();
        runTxn(16'h0010, 1'b1, 1'b1, 8'h00, 1, "conflict");
        runTxn(16'h0020, 1'b1, 1'b0, 8'h11, 5, "wr20");
        runTxn(16'h0020, 1'b1, 1'b0, 8'h77, 2, "wr20abort");
        runTxn(16'h0020, 1'b0, 1'b1, 8'h00, 5, "rd20");
    endtask

    task automatic test_write_protect();
        runTxn(16'h0090, 1'b1, 1'b0, 8'h55, 5, "wpWr90");
        runTxn(16'h0090, 1'b0, 1'b1, 8'h00, 5, "wpRd90");
        runTxn(16'h0010, 1'b1, 1'b0, 8'h5A, 5, "wpWr10");
        runTxn(16'h0010, 1'b0, 1'b1, 8'h00, 5, "wpRd10");
    endtask

    task automatic test_reset_mid_op();
        // Write interrupted while dut0 is in its memReady cycle: nothing lands.
        tbA = 16'h0020; tbWr = 1'b1; tbRd = 1'b0; tbData = 8'h99; tbDrv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nCmp++;
        if (rdy[0] !== 1'b1) begin nBad++; $display("FAIL midWr memReady dut0 got %b want %b", rdy[0], 1'b1); end
        rstN = 1'b0;
        #1;
        nCmp++;
        if (rdy !== 3'b000) begin nBad++; $display("FAIL midWr memReady after reset got %b want %b", rdy, 3'b000); end
        tbWr = 1'b0; tbDrv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        runTxn(16'h0020, 1'b0, 1'b1, 8'h00, 5, "rd20afterRst");

        // Read interrupted while dut0 drives data: bus released at once.
        tbA = 16'h0034; tbRd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nCmp++;
        if (dv[0] !== model[0][8'h34]) begin nBad++; $display("FAIL midRd extD dut0 got %h want %h", dv[0], model[0][8'h34]); end
        rstN = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            nCmp++;
            if (dv[k] !== 8'hFF) begin nBad++; $display("FAIL midRd release dut%0d got %h want %h", k, dv[k], 8'hFF); end
        end
        tbRd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] a;
        bit          wr;
        int          L;
        for (int n = 0; n < 60; n++) begin
            a[7:0]  = 8'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 8'h80 : 8'h00);
            a[15:8] = ($urandom_range(0, 4) == 0) ? 8'h01 : 8'h00;
            wr      = 1'($urandom_range(0, 1));
            L       = $urandom_range(1, 6);
            runTxn(a, wr, !wr, 8'($urandom_range(0, 254)), L, "random");
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 256; j++) begin
                known[k][j] = 1'b0;
                model[k][j] = 8'h00;
            end
        test_reset();
        test_select();
        test_write_read();
        test_zero_wait();
        test_deselect();
        test_conflict_abort();
`ifdef R88_WRITE_PROTECT_EN
        test_write_protect();
`endif
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
